// File: rtl/sn_ingress_receiver.sv
// rtl/sn_ingress_receiver.sv - SiliconNet shim ingress receiver: pad strip, phit FIFO, credit return
module sn_ingress_receiver #(
    parameter int FLIT_WIDTH      = 512,
    parameter int PHIT_WIDTH      = 128,
    parameter int NUM_PORTS       = 4,
    parameter int FLITS_PER_PORT  = 4,
    parameter int VC_WIDTH        = 2,
    localparam int PORT_W         = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
    localparam int PAD_W          = $clog2(PHIT_WIDTH / 8) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic [PHIT_WIDTH-1:0] lnk_ifc_in_data,
    input  logic                  lnk_ifc_in_first,
    input  logic                  lnk_ifc_in_last,
    input  logic [VC_WIDTH-1:0]   lnk_ifc_in_src_vc,
    input  logic [VC_WIDTH-1:0]   lnk_ifc_in_dst_vc,
    input  logic [PORT_W-1:0]     lnk_ifc_in_src_port,
    input  logic [PORT_W-1:0]     lnk_ifc_in_dst_port,
    input  logic [PAD_W-1:0]      lnk_ifc_in_pad_bytes,
    input  logic                  lnk_valid_in,

    output logic                  lnk_credit_out_valid,
    output logic [PORT_W-1:0]     lnk_credit_out_port,
    input  logic                  lnk_credack_in,

    output logic [PHIT_WIDTH-1:0] out_ifc_out_data,
    output logic                  out_ifc_out_first,
    output logic                  out_ifc_out_last,
    output logic [VC_WIDTH-1:0]   out_ifc_out_src_vc,
    output logic [VC_WIDTH-1:0]   out_ifc_out_dst_vc,
    output logic [PORT_W-1:0]     out_ifc_out_src_port,
    output logic [PORT_W-1:0]     out_ifc_out_dst_port,
    output logic [PAD_W-1:0]      out_ifc_out_pad_bytes,
    output logic                  out_valid_out,
    input  logic                  out_ready_in,

    output logic                  overflow_out
);

    localparam int PPF        = FLIT_WIDTH / PHIT_WIDTH;
    localparam int CNT_W      = $clog2(PPF);
    localparam int IFC_W      = PHIT_WIDTH + 2 + 2 * VC_WIDTH + 2 * PORT_W + PAD_W;
    localparam int ENTRY_W    = IFC_W + 1 + PORT_W;
    localparam int FIFO_DEPTH = NUM_PORTS * FLITS_PER_PORT * PPF;
    localparam int FIFO_AW    = $clog2(FIFO_DEPTH);
    localparam int FIFO_CW    = FIFO_AW + 1;
    localparam int CQ_DEPTH   = NUM_PORTS * FLITS_PER_PORT;
    localparam int CQ_AW      = $clog2(CQ_DEPTH);
    localparam int CQ_CW      = CQ_AW + 1;
    localparam int INIT_W     = $clog2(CQ_DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BODY = 2'd1,
        S_PAD  = 2'd2
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_phit_cnt;
    logic [PORT_W-1:0]   r_dst_port;

    logic                w_wrap;
    logic                w_store;
    logic                w_flit_end;
    logic [PORT_W-1:0]   w_entry_port;
    logic [ENTRY_W-1:0]  w_entry;

    logic [ENTRY_W-1:0]  r_fifo_mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0]  r_fifo_wr;
    logic [FIFO_AW-1:0]  r_fifo_rd;
    logic [FIFO_CW-1:0]  r_fifo_count;
    logic                r_overflow;
    logic                w_fifo_full;
    logic                w_fifo_push;
    logic                w_fifo_pop;
    logic [ENTRY_W-1:0]  w_head;
    logic                w_head_flit_end;
    logic [PORT_W-1:0]   w_head_port;

    logic [PORT_W-1:0]   r_cq_mem [CQ_DEPTH];
    logic [CQ_AW-1:0]    r_cq_wr;
    logic [CQ_AW-1:0]    r_cq_rd;
    logic [CQ_CW-1:0]    r_cq_count;
    logic                w_cq_full;
    logic                w_cq_push;
    logic                w_cq_pop;
    logic [PORT_W-1:0]   w_cq_head;

    logic                r_started;
    logic [INIT_W-1:0]   r_init_cnt;
    logic                w_init_active;
    logic                w_grant;

    // Ingress decode: which arriving phits are real, and which close a flit.
    assign w_wrap = (r_phit_cnt == CNT_W'(PPF - 1));

    always_comb begin
        w_store      = 1'b0;
        w_flit_end   = 1'b0;
        w_entry_port = r_dst_port;
        if (lnk_valid_in) begin
            case (r_state)
                S_IDLE: begin
                    w_store      = 1'b1;
                    w_flit_end   = lnk_ifc_in_last;
                    w_entry_port = lnk_ifc_in_dst_port;
                end
                S_BODY: begin
                    w_store    = 1'b1;
                    w_flit_end = w_wrap | lnk_ifc_in_last;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_phit_cnt <= '0;
            r_dst_port <= '0;
        end else if (lnk_valid_in) begin
            case (r_state)
                S_IDLE: begin
                    r_phit_cnt <= CNT_W'(1);
                    r_dst_port <= lnk_ifc_in_dst_port;
                    r_state    <= lnk_ifc_in_last ? S_PAD : S_BODY;
                end
                S_BODY: begin
                    r_phit_cnt <= w_wrap ? '0 : r_phit_cnt + CNT_W'(1);
                    if (lnk_ifc_in_last) begin
                        r_state <= w_wrap ? S_IDLE : S_PAD;
                    end
                end
                S_PAD: begin
                    r_phit_cnt <= w_wrap ? '0 : r_phit_cnt + CNT_W'(1);
                    if (w_wrap) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_phit_cnt <= '0;
                end
            endcase
        end
    end

    assign w_entry = {w_flit_end, w_entry_port,
                      lnk_ifc_in_data, lnk_ifc_in_first, lnk_ifc_in_last,
                      lnk_ifc_in_src_vc, lnk_ifc_in_dst_vc,
                      lnk_ifc_in_src_port, lnk_ifc_in_dst_port,
                      lnk_ifc_in_pad_bytes};

    // Phit FIFO, first-word-fall-through; a same-cycle pop makes room for a push into a full FIFO.
    assign out_valid_out = (r_fifo_count != '0);
    assign w_fifo_full   = (r_fifo_count == FIFO_CW'(FIFO_DEPTH));
    assign w_fifo_pop    = out_valid_out & out_ready_in;
    assign w_fifo_push   = w_store & (~w_fifo_full | w_fifo_pop);
    assign overflow_out  = r_overflow;

    assign w_head          = r_fifo_mem[r_fifo_rd];
    assign w_head_flit_end = w_head[ENTRY_W-1];
    assign w_head_port     = w_head[ENTRY_W-2 -: PORT_W];
    assign {out_ifc_out_data, out_ifc_out_first, out_ifc_out_last,
            out_ifc_out_src_vc, out_ifc_out_dst_vc,
            out_ifc_out_src_port, out_ifc_out_dst_port,
            out_ifc_out_pad_bytes} = w_head[IFC_W-1:0];

    always_ff @(posedge clk) begin
        if (w_fifo_push) begin
            r_fifo_mem[r_fifo_wr] <= w_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fifo_wr    <= '0;
            r_fifo_rd    <= '0;
            r_fifo_count <= '0;
            r_overflow   <= 1'b0;
        end else begin
            if (w_fifo_push) begin
                r_fifo_wr <= (r_fifo_wr == FIFO_AW'(FIFO_DEPTH - 1)) ? '0 : r_fifo_wr + FIFO_AW'(1);
            end
            if (w_fifo_pop) begin
                r_fifo_rd <= (r_fifo_rd == FIFO_AW'(FIFO_DEPTH - 1)) ? '0 : r_fifo_rd + FIFO_AW'(1);
            end
            case ({w_fifo_push, w_fifo_pop})
                2'b10:   r_fifo_count <= r_fifo_count + FIFO_CW'(1);
                2'b01:   r_fifo_count <= r_fifo_count - FIFO_CW'(1);
                default: ;
            endcase
            if (w_store && !w_fifo_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Credit output: the initial pool is granted round-robin before the return queue is served.
    assign w_init_active        = (r_init_cnt != INIT_W'(CQ_DEPTH));
    assign w_cq_head            = r_cq_mem[r_cq_rd];
    assign lnk_credit_out_valid = r_started & (w_init_active | (r_cq_count != '0));
    assign lnk_credit_out_port  = w_init_active ? r_init_cnt[PORT_W-1:0] : w_cq_head;
    assign w_grant              = lnk_credit_out_valid & lnk_credack_in;
    assign w_cq_pop             = w_grant & ~w_init_active;
    assign w_cq_full            = (r_cq_count == CQ_CW'(CQ_DEPTH));
    assign w_cq_push            = w_fifo_pop & w_head_flit_end & (~w_cq_full | w_cq_pop);

    always_ff @(posedge clk) begin
        if (w_cq_push) begin
            r_cq_mem[r_cq_wr] <= w_head_port;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_started  <= 1'b0;
            r_init_cnt <= '0;
            r_cq_wr    <= '0;
            r_cq_rd    <= '0;
            r_cq_count <= '0;
        end else begin
            r_started <= 1'b1;
            if (w_grant && w_init_active) begin
                r_init_cnt <= r_init_cnt + INIT_W'(1);
            end
            if (w_cq_push) begin
                r_cq_wr <= (r_cq_wr == CQ_AW'(CQ_DEPTH - 1)) ? '0 : r_cq_wr + CQ_AW'(1);
            end
            if (w_cq_pop) begin
                r_cq_rd <= (r_cq_rd == CQ_AW'(CQ_DEPTH - 1)) ? '0 : r_cq_rd + CQ_AW'(1);
            end
            case ({w_cq_push, w_cq_pop})
                2'b10:   r_cq_count <= r_cq_count + CQ_CW'(1);
                2'b01:   r_cq_count <= r_cq_count - CQ_CW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sn_ingress_receiver.sv
// tb/tb_sn_ingress_receiver.sv - scoreboard bench for sn_ingress_receiver
module tb_sn_ingress_receiver;
    localparam int FW    = 512;
    localparam int PW    = 128;
    localparam int NP    = 4;
    localparam int FPP   = 4;
    localparam int VCW   = 2;
    localparam int PPF   = FW / PW;
    localparam int PORTW = 2;
    localparam int PADW  = 5;
    localparam int NCRED = NP * FPP;

    typedef struct packed {
        logic [PW-1:0]    data;
        logic             first;
        logic             last;
        logic [VCW-1:0]   svc;
        logic [VCW-1:0]   dvc;
        logic [PORTW-1:0] sport;
        logic [PORTW-1:0] dport;
        logic [PADW-1:0]  pad;
    } ifc_t;

    typedef struct {
        ifc_t ifc;
        bit   fend;
    } ent_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [PW-1:0]    in_data  = '0;
    logic             in_first = 1'b0;
    logic             in_last  = 1'b0;
    logic [VCW-1:0]   in_svc   = '0;
    logic [VCW-1:0]   in_dvc   = '0;
    logic [PORTW-1:0] in_sport = '0;
    logic [PORTW-1:0] in_dport = '0;
    logic [PADW-1:0]  in_pad   = '0;
    logic             in_valid = 1'b0;
    logic             cvalid;
    logic [PORTW-1:0] cport;
    logic             credack = 1'b0;
    logic [PW-1:0]    o_data;
    logic             o_first, o_last;
    logic [VCW-1:0]   o_svc, o_dvc;
    logic [PORTW-1:0] o_sport, o_dport;
    logic [PADW-1:0]  o_pad;
    logic             out_valid;
    logic             ready = 1'b0;
    logic             ovf;

    sn_ingress_receiver #(
        .FLIT_WIDTH(FW), .PHIT_WIDTH(PW), .NUM_PORTS(NP), .FLITS_PER_PORT(FPP), .VC_WIDTH(VCW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .lnk_ifc_in_data(in_data), .lnk_ifc_in_first(in_first), .lnk_ifc_in_last(in_last),
        .lnk_ifc_in_src_vc(in_svc), .lnk_ifc_in_dst_vc(in_dvc),
        .lnk_ifc_in_src_port(in_sport), .lnk_ifc_in_dst_port(in_dport),
        .lnk_ifc_in_pad_bytes(in_pad), .lnk_valid_in(in_valid),
        .lnk_credit_out_valid(cvalid), .lnk_credit_out_port(cport), .lnk_credack_in(credack),
        .out_ifc_out_data(o_data), .out_ifc_out_first(o_first), .out_ifc_out_last(o_last),
        .out_ifc_out_src_vc(o_svc), .out_ifc_out_dst_vc(o_dvc),
        .out_ifc_out_src_port(o_sport), .out_ifc_out_dst_port(o_dport),
        .out_ifc_out_pad_bytes(o_pad), .out_valid_out(out_valid), .out_ready_in(ready),
        .overflow_out(ovf)
    );

    always #5 clk = ~clk;

    ent_t exp_q[$];
    int   exp_cred[$];
    int   credits[NP];
    int   total = 0;
    int   bad = 0;
    bit   mon_en = 1'b0;
    int   pop_cnt = 0;
    int   grant_cnt = 0;
    int   ready_mode = 0;
    int   ack_mode = 0;
    bit   stall_seen = 1'b0;
    logic [PORTW-1:0] stall_port = '0;
    ent_t mon_e;
    int   exp_port;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Output scoreboard: every consumed phit must be the next real phit sent.
    always @(negedge clk) begin
        if (mon_en && out_valid && ready) begin
            pop_cnt++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_phit: got data %0h required no phit", o_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("phit", {o_data, o_first, o_last, o_svc, o_dvc, o_sport, o_dport, o_pad}, mon_e.ifc);
                if (mon_e.fend) exp_cred.push_back(int'(mon_e.ifc.dport));
            end
        end
    end

    // Credit monitor: grants in expected order, and a pending grant holds steady.
    always @(negedge clk) begin
        if (mon_en) begin
            if (stall_seen) begin
                check("credit_hold_valid", cvalid, 1'b1);
                check("credit_hold_port", cport, stall_port);
            end
            stall_seen = cvalid && !credack;
            stall_port = cport;
            if (cvalid && credack) begin
                grant_cnt++;
                if (exp_cred.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_credit: got port %0d required no credit", cport);
                end else begin
                    exp_port = exp_cred.pop_front();
                    check("credit_port", cport, exp_port);
                end
                credits[cport]++;
            end
        end else begin
            stall_seen = 1'b0;
        end
    end

    // Sole driver of ready/credack: 0 = low, 1 = high, 2 = random.
    initial forever begin
        @(posedge clk);
        #2;
        ready   = (ready_mode == 2) ? ($urandom_range(0, 3) != 0) : (ready_mode == 1);
        credack = (ack_mode == 2) ? ($urandom_range(0, 4) != 0) : (ack_mode == 1);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    function automatic ifc_t rand_ifc(input int port, input bit first, input bit last);
        ifc_t f;
        f.data  = {$urandom, $urandom, $urandom, $urandom};
        f.first = first;
        f.last  = last;
        f.svc   = VCW'($urandom);
        f.dvc   = VCW'($urandom);
        f.sport = PORTW'($urandom);
        f.dport = PORTW'(port);
        f.pad   = PADW'($urandom);
        return f;
    endfunction

    task automatic drive(input ifc_t f);
        {in_data, in_first, in_last, in_svc, in_dvc, in_sport, in_dport, in_pad} = f;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_real(input int port, input int idx, input int len);
        ifc_t f;
        f = rand_ifc(port, idx == 1, idx == len);
        exp_q.push_back('{ifc: f, fend: ((idx % PPF) == 0) || (idx == len)});
        drive(f);
    endtask

    task automatic send_pad();
        drive(rand_ifc($urandom_range(0, NP - 1), 1'b0, 1'b0));
    endtask

    // A packet of len real phits occupies ceil(len/PPF) flits; the rest of the last flit is pad.
    task automatic send_packet(input int port, input int len, input bit gaps);
        int nfl;
        int t;
        nfl = (len + PPF - 1) / PPF;
        t = 0;
        while (credits[port] < nfl && t < 4000) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (credits[port] < nfl) begin
            total++;
            bad++;
            $display("FAIL credit_wait: port %0d holds %0d credits, required %0d", port, credits[port], nfl);
            return;
        end
        credits[port] -= nfl;
        for (int i = 1; i <= len; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send_real(port, i, len);
        end
        for (int i = 0; i < nfl * PPF - len; i++) send_pad();
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || exp_cred.size() != 0) && t < 5000) begin
            @(posedge clk);
            #1;
            t++;
        end
        total++;
        if (exp_q.size() != 0 || exp_cred.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: %0d phits and %0d credits outstanding, required 0",
                     tag, exp_q.size(), exp_cred.size());
        end
    endtask

    task automatic do_reset();
        mon_en   = 1'b0;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_credit_valid", cvalid, 1'b0);
        check("rst_overflow", ovf, 1'b0);
        exp_q.delete();
        exp_cred.delete();
        for (int p = 0; p < NP; p++) credits[p] = 0;
        for (int i = 0; i < NCRED; i++) exp_cred.push_back(i % NP);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic init_acked(input string tag);
        int g0;
        g0 = grant_cnt;
        repeat (NCRED) @(negedge clk);
        #1;
        check({tag, "_grants"}, grant_cnt - g0, NCRED);
        @(negedge clk);
        #1;
        check({tag, "_valid_after"}, cvalid, 1'b0);
        check({tag, "_grants_stop"}, grant_cnt - g0, NCRED);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int p0;
        int g0;
        rst_n = 1'b1;
        #3;
        ready_mode = 1;
        ack_mode   = 0;
        do_reset();

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("init_stall_valid", cvalid, 1'b1);
            check("init_stall_port", cport, 0);
        end
        @(posedge clk);
        #1;
        ack_mode = 1;
        init_acked("init1");

        credits[2] -= 1;
        send_real(2, 1, 1);
        @(negedge clk);
        check("ingress_latency", out_valid, 1'b1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("credit_latency_valid", cvalid, 1'b1);
        check("credit_latency_port", cport, 2);
        @(posedge clk);
        #1;
        for (int i = 0; i < PPF - 1; i++) send_pad();
        drain("single");

        send_packet(1, 6, 1'b0);
        drain("six");
        for (int p = 0; p < NP; p++) check("credits_home", credits[p], FPP);

        ready_mode = 0;
        @(posedge clk);
        #1;
        p0 = pop_cnt;
        g0 = grant_cnt;
        for (int i = 0; i < NCRED; i++) send_packet(i % NP, PPF, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("bp_out_valid", out_valid, 1'b1);
        check("bp_credit_valid", cvalid, 1'b0);
        check("bp_overflow", ovf, 1'b0);
        check("bp_no_pops", pop_cnt - p0, 0);
        @(posedge clk);
        #1;
        drive(rand_ifc(0, 1'b1, 1'b1));
        for (int i = 0; i < PPF - 1; i++) send_pad();
        @(negedge clk);
        check("overflow_set", ovf, 1'b1);
        @(posedge clk);
        #1;
        ready_mode = 1;
        drain("bp");
        check("bp_pop_total", pop_cnt - p0, NCRED * PPF);
        check("bp_credit_total", grant_cnt - g0, NCRED);
        check("overflow_sticky", ovf, 1'b1);

        ready_mode = 0;
        @(posedge clk);
        #1;
        drive(rand_ifc(3, 1'b1, 1'b0));
        @(negedge clk);
        check("pre_reset_valid", out_valid, 1'b1);
        @(posedge clk);
        #1;
        ready_mode = 1;
        ack_mode   = 1;
        do_reset();
        init_acked("init2");

        ready_mode = 2;
        ack_mode   = 2;
        for (int n = 0; n < 40; n++) send_packet($urandom_range(0, NP - 1), $urandom_range(1, 3 * PPF), 1'b1);
        ready_mode = 1;
        ack_mode   = 1;
        drain("random");
        for (int p = 0; p < NP; p++) check("credits_final", credits[p], FPP);
        check("final_overflow", ovf, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
